data_buffer: RTL
================

// Module: data_buffer
// PURPOSE
//  Endpoint byte FIFO between the AHB-lite slave register block and the USB RX/TX packet engines.
//  Bus-side ports: store_tx_data/tx_data (host writes) and get_rx_data/rx_data (host reads).
//  Packet-side ports: store_rx_packet_data (RX engine writes) and get_tx_packet_data (TX engine reads).
//  Reports buffer_occupancy to the register block; one shared storage array, one direction in use at a time.
// PARAMETERS
//  DEPTH   64  byte entries; power of two
//  OCC_W   7   occupancy/pointer width = $clog2(DEPTH)+1
// PORTS
//  clk                   in   1      system clock, rising edge
//  n_rst                 in   1      async active-low reset
//  clear                 in   1      sync flush from register block
//  store_tx_data         in   1      host write strobe
//  tx_data               in   8      host write byte
//  get_rx_data           in   1      host read strobe
//  rx_data               out  8      head byte to host (show-ahead)
//  store_rx_packet_data  in   1      RX engine write strobe
//  rx_packet_data        in   8      RX engine write byte
//  get_tx_packet_data    in   1      TX engine read strobe
//  tx_packet_data        out  8      head byte to TX engine (show-ahead)
//  buffer_occupancy      out  OCC_W  stored bytes, 0..DEPTH
// BEHAVIOUR
//  - Reset (n_rst=0, async): wptr=rptr=0, occupancy=0; rx_data/tx_packet_data=8'h00.
//    Array contents are not reset.
//  - Pointers are OCC_W bits: index = ptr[OCC_W-2:0]; MSB is the wrap bit.
//    occupancy = wptr - rptr, modulo 2^OCC_W. full when occupancy==DEPTH; empty when 0.
//  - Show-ahead read: rx_data = tx_packet_data = mem[rptr index], combinational, same cycle.
//    Both outputs are forced to 8'h00 when empty. A consumer samples the head in the cycle it pulses its get.
//  - Write (wr) = store_tx_data | store_rx_packet_data. If both are set, rx_packet_data is stored;
//    the tx_data byte is dropped.
//  - Read (rd) = get_rx_data | get_tx_packet_data. If both are set, one entry pops.
//  - One read and one write per cycle, latency 1: the entry is visible at head/occupancy the next cycle.
//  - Boundaries, evaluated on the current-cycle occupancy:
//    empty: rd ignored; rd+wr -> write only, occupancy 1
//    full:  wr alone dropped; rd+wr -> both accepted, occupancy stays DEPTH
//    wrap:  DEPTH-1 -> 0 index wrap is seamless; wrap bit toggles
//  - clear (sync): highest priority. Next cycle wptr=rptr=0 and occupancy=0.
//    Same-cycle reads and writes are discarded.
//  - Reset mid-transfer aborts instantly; no partial-state recovery.
// CONFIGURATION
//  - `DATA_BUFFER_ERR_EN defined: adds outputs overflow (1) and underflow (1), both sticky.
//    overflow sets on a dropped write at full, or on the tx byte dropped by a simultaneous write.
//    underflow sets on a read at empty. Both cleared by clear or reset; reset value 0.
//  - Not defined: the ports do not exist; drops are silent.
// STRUCTURE
//  - usb_buffer_pkg: BUF_DEPTH=64, BUF_OCC_W=7, typedef logic [7:0] byte_t, typedef logic [6:0] occ_t.
//  - Sub-module buffer_ptr: OCC_W-bit pointer with inc/clear, instantiated twice (write and read).
//    Array, arbitration and flags live in data_buffer.
// TESTING
//  1 Reset, then write 0x11,0x22,0x33 via store_rx_packet_data
//    -> occupancy 3; rx_data=0x11; get_rx_data x3 returns 0x11,0x22,0x33; occupancy 0; rx_data=0x00.
//  2 Write 64 bytes 0x00..0x3F via store_tx_data, then one more write 0xFF
//    -> occupancy holds 64; 0xFF dropped; overflow=1 if ERR_EN; tx_packet_data reads 0x00..0x3F in order.
//  3 Full, then rd+wr same cycle with 0xAA -> occupancy 64; after 63 pops the head is 0xAA.
//  4 Empty, then get_tx_packet_data with store_rx_packet_data=0x5C -> occupancy 1, head 0x5C;
//    underflow stays 0. A read on empty alone -> underflow=1.
//  5 Occupancy 10, then clear with simultaneous wr+rd -> next cycle occupancy 0, outputs 0x00, flags 0.
//  6 Fill/drain 40 bytes three times to exercise pointer wrap -> data order preserved;
//    occupancy matches the model every cycle.

Source files
------------

// File: rtl/usb_buffer_pkg.sv
// Shared types and sizing for the USB endpoint byte buffer.
// Pure declarations: no logic, no latency, no flow control.
// Occupancy and pointer values carry one extra wrap bit above the array index.
package usb_buffer_pkg;

    localparam int BUF_DEPTH = 64;
    localparam int BUF_OCC_W = 7;

    typedef logic [7:0]           byte_t;
    typedef logic [BUF_OCC_W-1:0] occ_t;

    // Modulo-2^OCC_W distance; the wrap bit makes full and empty distinct.
    function automatic occ_t occ_diff(input occ_t wptr, input occ_t rptr);
        return wptr - rptr;
    endfunction

endpackage

// File: rtl/buffer_ptr.sv
// Wrap-bit pointer with synchronous clear and increment.
// Latency: the new value is visible one cycle after i_inc or i_clr.
// No backpressure: the owner gates i_inc; i_clr has priority over i_inc.
module buffer_ptr
    import usb_buffer_pkg::*;
#(
    parameter int W = BUF_OCC_W
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/data_buffer.sv
// Endpoint byte FIFO shared by host bus and USB RX/TX packet engines; optional DATA_BUFFER_ERR_EN adds sticky overflow/underflow.
// Latency: a write appears at head/occupancy next cycle; head is show-ahead (combinational).
// Backpressure: none; writes at full (without a read) and reads at empty are dropped.
module data_buffer
    import usb_buffer_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int OCC_W = BUF_OCC_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             store_tx_data,
    input  byte_t            tx_data,
    input  logic             get_rx_data,
    output byte_t            rx_data,
    input  logic             store_rx_packet_data,
    input  byte_t            rx_packet_data,
    input  logic             get_tx_packet_data,
    output byte_t            tx_packet_data,
    output logic [OCC_W-1:0] buffer_occupancy
`ifdef DATA_BUFFER_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    logic [OCC_W-1:0] w_wptr;
    logic [OCC_W-1:0] w_rptr;
    logic [OCC_W-1:0] w_occ;
    logic [OCC_W-2:0] w_widx;
    logic [OCC_W-2:0] w_ridx;
    logic             w_wr;
    logic             w_rd;
    logic             w_full;
    logic             w_empty;
    logic             w_do_wr;
    logic             w_do_rd;
    byte_t            w_wdat;
    byte_t            w_head;
    byte_t            r_mem [DEPTH];

    assign w_wr    = store_tx_data | store_rx_packet_data;
    assign w_rd    = get_rx_data | get_tx_packet_data;
    // The RX engine owns the write port when both producers strobe together.
    assign w_wdat  = store_rx_packet_data ? rx_packet_data : tx_data;

    assign w_occ   = occ_diff(w_wptr, w_rptr);
    assign w_full  = (w_occ == OCC_W'(DEPTH));
    assign w_empty = (w_occ == '0);
    assign w_widx  = w_wptr[OCC_W-2:0];
    assign w_ridx  = w_rptr[OCC_W-2:0];

    // At full a simultaneous pop frees the slot the write lands in.
    assign w_do_wr = w_wr & ~clear & (~w_full | w_rd);
    assign w_do_rd = w_rd & ~clear & ~w_empty;

    buffer_ptr #(.W(OCC_W)) u_wptr (
        .clk   (clk),
        .n_rst (n_rst),
        .i_clr (clear),
        .i_inc (w_do_wr),
        .o_ptr (w_wptr)
    );

    buffer_ptr #(.W(OCC_W)) u_rptr (
        .clk   (clk),
        .n_rst (n_rst),
        .i_clr (clear),
        .i_inc (w_do_rd),
        .o_ptr (w_rptr)
    );

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[w_widx] <= w_wdat;
        end
    end

    // Forcing zero on empty also hides the unreset array contents.
    assign w_head           = w_empty ? 8'h00 : r_mem[w_ridx];
    assign rx_data          = w_head;
    assign tx_packet_data   = w_head;
    assign buffer_occupancy = w_occ;

`ifdef DATA_BUFFER_ERR_EN
    logic w_ovf_set;
    logic w_unf_set;
    logic r_overflow;
    logic r_underflow;

    assign w_ovf_set = (w_wr & w_full & ~w_rd) | (store_tx_data & store_rx_packet_data);
    assign w_unf_set = w_rd & ~w_wr & w_empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow  | w_ovf_set;
            r_underflow <= r_underflow | w_unf_set;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
